// File: rtl/button_conditioner.sv
// button_conditioner: two-flop synchroniser, counter debouncer and press/release pulse generator.
// Define BTN_REPEAT_EN to add auto-repeat press pulses on channels selected by REPEAT_MASK.
module button_conditioner #(
  parameter int                 NUM_BTN         = 4,
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 CNT_W           = 20,
  parameter int                 REPEAT_DELAY    = 50000000,
  parameter int                 REPEAT_PERIOD   = 10000000,
  parameter int                 REP_W           = 26,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b0010
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || CNT_W < $clog2(DEBOUNCE_CYCLES) || $bits(REPEAT_MASK) != NUM_BTN ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      REP_W < $clog2(REPEAT_DELAY) || REP_W < $clog2(REPEAT_PERIOD)) begin : g_bad_params
    $error("button_conditioner: inconsistent parameters");
  end

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_accept;
  logic [NUM_BTN-1:0] w_edge_press;
  logic [NUM_BTN-1:0] w_rep_fire;

  // A new level is accepted on the edge that would take the count past its limit.
  always_comb begin
    w_accept = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      if (r_sync2[i] != r_level[i] && r_cnt[i] == C_MAX) begin
        w_accept[i] = 1'b1;
      end else begin
        w_accept[i] = 1'b0;
      end
    end
  end

  assign w_edge_press = w_accept & r_sync2;

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= {NUM_BTN{1'b0}};
      r_sync2 <= {NUM_BTN{1'b0}};
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce counters, accepted level and registered edge pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_level   <= {NUM_BTN{1'b0}};
      r_press   <= {NUM_BTN{1'b0}};
      r_release <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= {CNT_W{1'b0}};
        end else if (w_accept[i]) begin
          r_cnt[i]   <= {CNT_W{1'b0}};
          r_level[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + C_ONE;
        end
      end
      r_press   <= w_edge_press | w_rep_fire;
      r_release <= w_accept & ~r_sync2;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE   = REP_W'(1);

  logic [REP_W-1:0]   r_rep [NUM_BTN];
  logic [NUM_BTN-1:0] r_rep_after_first;

  // A release being accepted this cycle suppresses any repeat that would coincide with it.
  always_comb begin
    w_rep_fire = {NUM_BTN{1'b0}};
    for (int i = 0; i < NUM_BTN; i++) begin
      if (REPEAT_MASK[i] && r_level[i] && !w_accept[i] &&
          r_rep[i] == (r_rep_after_first[i] ? REP_NEXT : REP_FIRST)) begin
        w_rep_fire[i] = 1'b1;
      end else begin
        w_rep_fire[i] = 1'b0;
      end
    end
  end

  // Repeat timers: restart on every press pulse, idle while released.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rep_after_first <= {NUM_BTN{1'b0}};
      for (int i = 0; i < NUM_BTN; i++) begin
        r_rep[i] <= {REP_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_accept[i] || !r_level[i] || !REPEAT_MASK[i]) begin
          r_rep[i]             <= {REP_W{1'b0}};
          r_rep_after_first[i] <= 1'b0;
        end else if (w_rep_fire[i]) begin
          r_rep[i]             <= {REP_W{1'b0}};
          r_rep_after_first[i] <= 1'b1;
        end else begin
          r_rep[i] <= r_rep[i] + REP_ONE;
        end
      end
    end
  end
`else
  assign w_rep_fire = {NUM_BTN{1'b0}};
`endif

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule
